spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_W-bit frame per accepted start, MSB first,
// with a lead/trail time and an inter-frame gap of CLK_DIV cycles each.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso1,
  output logic              ss1,
  output logic              sclk,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, XFER, TRAIL, GAP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  // Bits still to be sent after the one currently on mosi.
  logic [DATA_W-2:0] tx_rest, tx_rest_nxt;
  logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic              sclk_nxt, ss1_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic              half_end;

  assign half_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_rest  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      ss1      <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      tx_rest  <= tx_rest_nxt;
      rx_shift <= rx_shift_nxt;
      rx_data  <= rx_data_nxt;
      sclk     <= sclk_nxt;
      ss1      <= ss1_nxt;
      mosi     <= mosi_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // All pin values are computed here and registered above, so the pins never glitch.
  always_comb begin
    state_nxt    = state;
    div_nxt      = div_cnt;
    bit_nxt      = bit_cnt;
    tx_rest_nxt  = tx_rest;
    rx_shift_nxt = rx_shift;
    rx_data_nxt  = rx_data;
    sclk_nxt     = sclk;
    ss1_nxt      = ss1;
    mosi_nxt     = mosi;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = XFER;
          tx_rest_nxt = tx_data[DATA_W-2:0];
          mosi_nxt    = tx_data[DATA_W-1];
          ss1_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          sclk_nxt    = 1'b0;
          div_nxt     = '0;
          bit_nxt     = '0;
        end
      end
      XFER: begin
        if (!half_end) begin
          div_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_nxt = '0;
          if (!sclk) begin
            sclk_nxt     = 1'b1;
            rx_shift_nxt = {rx_shift[DATA_W-2:0], miso1};
          end else begin
            sclk_nxt = 1'b0;
            // The last bit stays on mosi through the trail time.
            if (bit_cnt == BIT_LAST) begin
              state_nxt = TRAIL;
            end else begin
              bit_nxt     = bit_cnt + BIT_W'(1);
              mosi_nxt    = tx_rest[DATA_W-2];
              tx_rest_nxt = tx_rest << 1;
            end
          end
        end
      end
      TRAIL: begin
        if (!half_end) begin
          div_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_nxt     = '0;
          state_nxt   = GAP;
          ss1_nxt     = 1'b1;
          mosi_nxt    = 1'b0;
          done_nxt    = 1'b1;
          rx_data_nxt = rx_shift;
        end
      end
      GAP: begin
        if (!half_end) begin
          div_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
